// File: rtl/lava_pkg.sv
// Shared types and helpers for the metaball lava-lamp display pipeline.
package lava_pkg;

  localparam int DISP_WIDTH  = 32;
  localparam int DISP_HEIGHT = 64;

  // 16.16 unsigned fixed-point field strength
  typedef logic [31:0] fix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_SAMPLE,
    S_SUM,
    S_OUT,
    S_MOVE
  } sched_state_t;

  function automatic fix_t sat_add(input fix_t a, input fix_t b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame-rate divider; pulses tick once every FRAME_DIV cycles.
module frame_tick_gen #(
  parameter int FRAME_DIV = 1666667
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(FRAME_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/metaball_frame_sched.sv
// Frame scheduler: sweeps the display per frame tick, thresholds the summed
// metaball field per pixel, hands pixels downstream and strobes the position update.
module metaball_frame_sched
  import lava_pkg::*;
#(
  parameter int   WIDTH     = DISP_WIDTH,
  parameter int   HEIGHT    = DISP_HEIGHT,
  parameter int   N_BALLS   = 4,
  parameter fix_t THRESH    = 32'h0001_0000,
  parameter int   FRAME_DIV = 1666667,
  parameter int   LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  output int                   p_x,
  output int                   p_y,
  input  logic [N_BALLS*32-1:0] ball_out,
  output logic                 mov_en,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output int                   pix_x,
  output int                   pix_y,
  output logic                 pix_on,
  output logic                 frame_done,
  output logic                 overrun
);

  sched_state_t state, state_nxt;
  logic         tick;
  logic         pending;
  logic [3:0]   wait_cnt;
  fix_t         sum, sum_comb;
  logic         last_wait, last_pix, busy;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign last_wait  = (wait_cnt == 4'(LAT - 1));
  assign last_pix   = (p_x == WIDTH - 1) && (p_y == HEIGHT - 1);
  assign busy       = (state == S_SAMPLE) || (state == S_SUM) ||
                      (state == S_OUT)    || (state == S_MOVE);
  // MOVE only follows an accepted last pixel, so these can never overlap pix_valid
  assign mov_en     = (state == S_MOVE);
  assign frame_done = (state == S_MOVE);

  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < N_BALLS; i++) sum_comb = sat_add(sum_comb, ball_out[32*i +: 32]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no branch infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (run) state_nxt = S_WAIT_TICK;
      S_WAIT_TICK: if (tick || pending) state_nxt = S_SAMPLE;
      S_SAMPLE:    if (last_wait) state_nxt = S_SUM;
      S_SUM:       state_nxt = S_OUT;
      S_OUT:       if (pix_ready) state_nxt = last_pix ? S_MOVE : S_SAMPLE;
      S_MOVE:      state_nxt = run ? S_WAIT_TICK : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_x       <= 0;
      p_y       <= 0;
      pix_x     <= 0;
      pix_y     <= 0;
      pix_on    <= 1'b0;
      pix_valid <= 1'b0;
      overrun   <= 1'b0;
      pending   <= 1'b0;
      wait_cnt  <= '0;
      sum       <= '0;
    end else begin
      // A tick that lands mid-frame is remembered once so the next frame starts immediately
      if (state == S_WAIT_TICK) begin
        pending <= 1'b0;
      end else if (busy && tick) begin
        pending <= 1'b1;
        overrun <= 1'b1;
      end

      case (state)
        S_WAIT_TICK: begin
          if (tick || pending) begin
            p_x      <= 0;
            p_y      <= 0;
            wait_cnt <= '0;
          end
        end
        S_SAMPLE: begin
          if (last_wait) begin
            sum      <= sum_comb;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_SUM: begin
          pix_on    <= (sum >= THRESH);
          pix_x     <= p_x;
          pix_y     <= p_y;
          pix_valid <= 1'b1;
        end
        S_OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (p_x == WIDTH - 1) begin
              p_x <= 0;
              p_y <= (p_y == HEIGHT - 1) ? 0 : p_y + 1;
            end else begin
              p_x <= p_x + 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_metaball_frame_sched.sv
// Self-checking bench for metaball_frame_sched: directed frames plus randomized
// field values and backpressure, checked against a pixel-order/threshold model.
module tb_metaball_frame_sched;

  localparam int          W        = 4;
  localparam int          H        = 2;
  localparam int          NB       = 2;
  localparam int          LATV     = 2;
  localparam logic [31:0] THRESH_V = 32'h0001_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            run = 1'b0;
  logic [NB*32-1:0] ball_out = '0;
  logic            pix_ready = 1'b1;
  int              p_x, p_y, pix_x, pix_y;
  logic            mov_en, pix_valid, pix_on, frame_done, overrun;

  logic            run2 = 1'b0;
  logic            ready2 = 1'b1;
  int              p_x_2, p_y_2, pix_x_2, pix_y_2;
  logic            mov_en_2, pix_valid_2, pix_on_2, frame_done_2, overrun_2;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_on;

  always #5 clk = ~clk;

  metaball_frame_sched #(
    .WIDTH(W), .HEIGHT(H), .N_BALLS(NB), .THRESH(THRESH_V), .FRAME_DIV(100), .LAT(LATV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .p_x(p_x), .p_y(p_y), .ball_out(ball_out),
    .mov_en(mov_en), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
    .pix_y(pix_y), .pix_on(pix_on), .frame_done(frame_done), .overrun(overrun)
  );

  metaball_frame_sched #(
    .WIDTH(W), .HEIGHT(H), .N_BALLS(NB), .THRESH(THRESH_V), .FRAME_DIV(20), .LAT(LATV)
  ) dut_ovr (
    .clk(clk), .rst_n(rst_n), .run(run2), .p_x(p_x_2), .p_y(p_y_2), .ball_out(ball_out),
    .mov_en(mov_en_2), .pix_valid(pix_valid_2), .pix_ready(ready2), .pix_x(pix_x_2),
    .pix_y(pix_y_2), .pix_on(pix_on_2), .frame_done(frame_done_2), .overrun(overrun_2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: unsigned sum of all words, clamped at 32'hFFFF_FFFF, compared to threshold
  function automatic bit exp_on_of(input logic [NB*32-1:0] b);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) s = s + {32'b0, b[32*i +: 32]};
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return s >= {32'b0, THRESH_V};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 32'h0000_FFFF));
      1:       return 32'($urandom_range(32'h0000_7F00, 32'h0000_8100));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pix_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full frame: checks pixel order, pix_on, stall stability, spacing and the MOVE pulse
  task automatic do_frame(input string name, input int stall_idx, input int stall_len,
                          input bit rnd_ready, input bit rnd_ball, input int drop_run_idx);
    int idx = 0;
    int stalled = 0;
    int last_acc = -1;
    int cyc = 0;
    bit ok;
    bit rdy;
    exp_on = exp_on_of(ball_out);
    wait_valid(400, ok);
    check({name, "_start_timeout"}, ok, 1);
    if (!ok) return;
    while (idx < W * H && cyc < 2000) begin
      check({name, "_mov_en_midframe"}, mov_en, 0);
      if (pix_valid) begin
        if (idx == stall_idx && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
          check({name, "_stall_pix_x"}, pix_x, idx % W);
          check({name, "_stall_pix_y"}, pix_y, idx / W);
          check({name, "_stall_p_x"}, p_x, idx % W);
          check({name, "_stall_pix_on"}, pix_on, exp_on);
        end else begin
          rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rdy) begin
          check({name, "_pix_x"}, pix_x, idx % W);
          check({name, "_pix_y"}, pix_y, idx / W);
          check({name, "_pix_on"}, pix_on, exp_on);
          if (!rnd_ready && stall_len == 0 && last_acc >= 0)
            check({name, "_spacing"}, cyc - last_acc, LATV + 2);
          last_acc = cyc;
          idx++;
          if (rnd_ball) begin
            ball_out = {rand_word(), rand_word()};
            exp_on   = exp_on_of(ball_out);
          end
          if (idx == drop_run_idx) run = 1'b0;
        end
        pix_ready = rdy;
      end else begin
        pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, "_all_pixels"}, idx, W * H);
    pix_ready = 1'b1;
    check({name, "_mov_en_pulse"}, mov_en, 1);
    check({name, "_frame_done_pulse"}, frame_done, 1);
    check({name, "_no_valid_at_move"}, pix_valid, 0);
    @(negedge clk);
    check({name, "_mov_en_once"}, mov_en, 0);
    check({name, "_frame_done_once"}, frame_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  bad;
    bit  ok;

    // Reset state
    ball_out = {32'h0000_8000, 32'h0000_8000};
    run  = 1'b1;
    run2 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_p_x", p_x, 0);
    check("rst_p_y", p_y, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_on", pix_on, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_mov_en", mov_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Overrun: a 20-cycle frame period is shorter than one sweep
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mov_en_2) begin
        ok = 1'b1;
        break;
      end
    end
    check("ovr_first_move", ok, 1);
    check("ovr_sticky", overrun_2, 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!pix_valid_2 && c < 60);
    check("ovr_restart_latency", c, LATV + 3);

    // Frame sweep, sum exactly at threshold
    do_frame("sweep", -1, 0, 1'b0, 1'b0, -1);
    check("sweep_overrun", overrun, 0);

    // Saturation with backpressure on pixel (2,0)
    ball_out = {32'hFFFF_0000, 32'h0002_0000};
    do_frame("sat_stall", 2, 10, 1'b0, 1'b0, -1);

    // Saturation that a wrapping adder would turn into zero
    ball_out = {32'hFFFF_8000, 32'h0000_8000};
    do_frame("sat_wrap", -1, 0, 1'b0, 1'b0, -1);

    // Just below threshold
    ball_out = {32'h0000_7FFF, 32'h0000_8000};
    do_frame("below", -1, 0, 1'b0, 1'b0, -1);

    // Randomized field values and backpressure
    for (int f = 0; f < 4; f++) begin
      ball_out = {rand_word(), rand_word()};
      do_frame("rand", -1, 0, 1'b1, 1'b1, -1);
    end

    // Run deasserted mid-frame: frame completes, then stays idle across ticks
    ball_out = {32'h0001_0000, 32'h0000_0000};
    do_frame("run_drop", -1, 0, 1'b0, 1'b0, 3);
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      if (pix_valid || mov_en) bad++;
      @(negedge clk);
    end
    check("idle_quiet", bad, 0);
    check("idle_overrun", overrun, 0);

    // Reset while presenting pixel (1,1)
    run = 1'b1;
    pix_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pix_valid && pix_x == 1 && pix_y == 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_reach", ok, 1);
    pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_p_x", p_x, 0);
    check("rst_mid_p_y", p_y, 0);
    check("rst_mid_pix_x", pix_x, 0);
    check("rst_mid_pix_y", pix_y, 0);
    check("rst_mid_pix_valid", pix_valid, 0);
    check("rst_mid_pix_on", pix_on, 0);
    check("rst_mid_mov_en", mov_en, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mov_en || frame_done) bad++;
    end
    check("rst_mid_no_move", bad, 0);
    rst_n = 1'b1;
    pix_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_valid || mov_en) bad++;
    end
    check("rst_restart_waits_tick", bad, 0);
    ball_out = {32'h0000_4000, 32'h0000_4000};
    do_frame("after_rst", -1, 0, 1'b0, 1'b0, -1);
    check("final_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
